// File: rtl/rgb_pkg.sv
// Shared types and field positions for the RGB quantizer control block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rgb_pkg;

  // Field positions inside the CPU-visible config byte.
  localparam int CFG_UP_ALLOW  = 0;
  localparam int CFG_BOOST     = 1;
  localparam int CFG_DITHER_EN = 2;
  localparam int CFG_DMODE_LO  = 3;
  localparam int CFG_DMODE_HI  = 4;
  localparam int CFG_APPLY_NOW = 5;
  localparam int CFG_W         = 6;

  // Which phase bits drive the dither strobe.
  typedef enum logic [1:0] {
    DM_PIX     = 2'b00,
    DM_PIXLINE = 2'b01,
    DM_ALL     = 2'b10,
    DM_FRAME   = 2'b11
  } dmode_e;

  // Stored config; bits [7:6] of a write are dropped.
  typedef struct packed {
    logic   apply_now;
    dmode_e dmode;
    logic   dither_en;
    logic   boost;
    logic   up_allow;
  } cfg_t;

endpackage

// File: rtl/rgb_if.sv
// CPU config bus between the port decoder and the RGB control block.
// Latency: readback is combinational from the stored shadow/pending state.
// Backpressure: none; every write strobe is accepted.
interface rgb_if;
  logic       cfg_wr;
  logic [7:0] cfg_data;
  logic [7:0] cfg_q;

  modport master (output cfg_wr, output cfg_data, input cfg_q);
  modport slave  (input cfg_wr, input cfg_data, output cfg_q);
endinterface

// File: rtl/rgb_dither_seq.sv
// Pixel/line/frame phase counters and the dither strobe selector.
// Latency: strobe is registered, one clk28 after the phase or config change.
// Backpressure: none; timing pulses are consumed as they arrive.
module rgb_dither_seq
  import rgb_pkg::*;
#(
  parameter int FRAME_DIV = 1
) (
  input  logic   clk28,
  input  logic   rst_n,
  input  logic   ck7,
  input  logic   hsync_start,
  input  logic   vsync_start,
  input  logic   dither_en,
  input  dmode_e dmode,
  output logic   strobe
);

  localparam logic [3:0] FRAME_LAST = 4'(FRAME_DIV - 1);

  logic       pix_ph;
  logic       line_ph;
  logic       frame_ph;
  logic [3:0] frame_cnt;
  logic       strobe_nxt;

  // Phase counters: line start restarts the pixel phase, frame start restarts the line phase.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      pix_ph    <= 1'b0;
      line_ph   <= 1'b0;
      frame_ph  <= 1'b0;
      frame_cnt <= 4'd0;
    end else begin
      if (hsync_start) begin
        pix_ph <= 1'b0;
      end else if (ck7) begin
        pix_ph <= ~pix_ph;
      end

      if (vsync_start) begin
        line_ph <= 1'b0;
      end else if (hsync_start) begin
        line_ph <= ~line_ph;
      end

      if (vsync_start) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= 4'd0;
          frame_ph  <= ~frame_ph;
        end else begin
          frame_cnt <= frame_cnt + 4'd1;
        end
      end
    end
  end

  // Strobe source select; held high when dithering is off.
  always_comb begin
    strobe_nxt = 1'b1;
    if (dither_en) begin
      case (dmode)
        DM_PIX:     strobe_nxt = pix_ph;
        DM_PIXLINE: strobe_nxt = pix_ph ^ line_ph;
        DM_ALL:     strobe_nxt = pix_ph ^ line_ph ^ frame_ph;
        DM_FRAME:   strobe_nxt = frame_ph;
        default:    strobe_nxt = 1'b1;
      endcase
    end
  end

  // Register the strobe so the quantizer sees a clean clk28-aligned signal.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      strobe <= 1'b1;
    end else begin
      strobe <= strobe_nxt;
    end
  end

endmodule

// File: rtl/rgb_ctl.sv
// Config double-buffer, dither sequencing and mode priority for the RGB quantizer.
// Latency: outputs registered, one clk28 after the active config/input change.
// Backpressure: none; config writes and timing pulses are always accepted.
module rgb_ctl
  import rgb_pkg::*;
#(
  parameter logic [7:0] RESET_CFG = 8'h00,
  parameter int         FRAME_DIV = 1
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic ck7,
  input  logic hsync_start,
  input  logic vsync_start,
  input  logic ulaplus_active,
  rgb_if.slave cfg_bus,
  output logic strobe,
  output logic up_en,
  output logic bright_boost
);

  localparam cfg_t CFG_RST = cfg_t'(RESET_CFG[CFG_W-1:0]);

  cfg_t shadow;
  cfg_t active;
  cfg_t wr_cfg;
  logic pending;
  logic up_req;
  logic unused_bits;

  assign wr_cfg      = cfg_t'(cfg_bus.cfg_data[CFG_W-1:0]);
  assign up_req      = active.up_allow & ulaplus_active;
  assign unused_bits = ^{cfg_bus.cfg_data[7:6], active.apply_now};

  // Shadow/active double buffer: writes land in shadow and reach active at frame
  // start, unless apply_now is set or the write coincides with frame start.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= CFG_RST;
      active  <= CFG_RST;
      pending <= 1'b0;
    end else if (cfg_bus.cfg_wr) begin
      shadow <= wr_cfg;
      if (wr_cfg.apply_now || vsync_start) begin
        active  <= wr_cfg;
        pending <= 1'b0;
      end else begin
        pending <= 1'b1;
      end
    end else if (vsync_start && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end
  end

  // Mode outputs: ULA+ quantization wins over bright boost so they never overlap.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      up_en        <= 1'b0;
      bright_boost <= 1'b0;
    end else begin
      up_en        <= up_req;
      bright_boost <= active.boost & ~up_req;
    end
  end

  assign cfg_bus.cfg_q = {pending, 1'b0, shadow};

  rgb_dither_seq #(
    .FRAME_DIV (FRAME_DIV)
  ) u_dither_seq (
    .clk28       (clk28),
    .rst_n       (rst_n),
    .ck7         (ck7),
    .hsync_start (hsync_start),
    .vsync_start (vsync_start),
    .dither_en   (active.dither_en),
    .dmode       (active.dmode),
    .strobe      (strobe)
  );

endmodule

// File: tb/tb_rgb_ctl.sv
// Randomized and directed bench for rgb_ctl, two instances (FRAME_DIV 1 and 2).
// Latency: expected outputs are derived from event counts one clk28 behind inputs.
// Backpressure: n/a.
module tb_rgb_ctl;

  logic       clk28 = 1'b0;
  logic       rst_n = 1'b1;
  logic       ck7 = 1'b0;
  logic       hsync_start = 1'b0;
  logic       vsync_start = 1'b0;
  logic       ulaplus_active = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [7:0] cfg_data = 8'h00;

  logic strobe1, up1, boost1;
  logic strobe2, up2, boost2;

  rgb_if bus1 ();
  rgb_if bus2 ();

  assign bus1.cfg_wr   = cfg_wr;
  assign bus1.cfg_data = cfg_data;
  assign bus2.cfg_wr   = cfg_wr;
  assign bus2.cfg_data = cfg_data;

  rgb_ctl #(.RESET_CFG(8'h00), .FRAME_DIV(1)) dut1 (
    .clk28          (clk28),
    .rst_n          (rst_n),
    .ck7            (ck7),
    .hsync_start    (hsync_start),
    .vsync_start    (vsync_start),
    .ulaplus_active (ulaplus_active),
    .cfg_bus        (bus1.slave),
    .strobe         (strobe1),
    .up_en          (up1),
    .bright_boost   (boost1)
  );

  rgb_ctl #(.RESET_CFG(8'h00), .FRAME_DIV(2)) dut2 (
    .clk28          (clk28),
    .rst_n          (rst_n),
    .ck7            (ck7),
    .hsync_start    (hsync_start),
    .vsync_start    (vsync_start),
    .ulaplus_active (ulaplus_active),
    .cfg_bus        (bus2.slave),
    .strobe         (strobe2),
    .up_en          (up2),
    .bright_boost   (boost2)
  );

  always #5 clk28 = ~clk28;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: config state plus plain event counts; phases are parities of counts.
  logic [5:0] m_shadow, m_active;
  logic       m_pending;
  int         m_ck, m_hs, m_vs;
  logic       m_strobe [2];
  logic       m_up, m_boost;
  int         div_of [2] = '{1, 2};

  function automatic logic ref_strobe(input logic [5:0] a, input int ck_n, input int hs_n,
                                      input int vs_n, input int div);
    logic pix, line, frame;
    logic [1:0] dm;
    pix   = (ck_n % 2) == 1;
    line  = (hs_n % 2) == 1;
    frame = ((vs_n / div) % 2) == 1;
    dm    = a[4:3];
    if (!a[2]) return 1'b1;
    case (dm)
      2'd0:    return pix;
      2'd1:    return pix ^ line;
      2'd2:    return pix ^ line ^ frame;
      default: return frame;
    endcase
  endfunction

  task automatic model_reset();
    m_shadow  = 6'h00;
    m_active  = 6'h00;
    m_pending = 1'b0;
    m_ck = 0; m_hs = 0; m_vs = 0;
    m_strobe[0] = 1'b1;
    m_strobe[1] = 1'b1;
    m_up = 1'b0;
    m_boost = 1'b0;
  endtask

  task automatic model_edge();
    logic want_up;
    for (int k = 0; k < 2; k++) m_strobe[k] = ref_strobe(m_active, m_ck, m_hs, m_vs, div_of[k]);
    want_up = m_active[0] & ulaplus_active;
    m_up    = want_up;
    m_boost = m_active[1] & ~want_up;
    if (hsync_start) m_ck = 0; else if (ck7) m_ck++;
    if (vsync_start) m_hs = 0; else if (hsync_start) m_hs++;
    if (vsync_start) m_vs++;
    if (cfg_wr) begin
      m_shadow = cfg_data[5:0];
      if (cfg_data[5] || vsync_start) begin
        m_active  = cfg_data[5:0];
        m_pending = 1'b0;
      end else begin
        m_pending = 1'b1;
      end
    end else if (vsync_start && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("strobe_div1", 8'(strobe1), 8'(m_strobe[0]));
    chk("strobe_div2", 8'(strobe2), 8'(m_strobe[1]));
    chk("up_en_1", 8'(up1), 8'(m_up));
    chk("up_en_2", 8'(up2), 8'(m_up));
    chk("boost_1", 8'(boost1), 8'(m_boost));
    chk("boost_2", 8'(boost2), 8'(m_boost));
    chk("cfg_q_1", bus1.cfg_q, {m_pending, 1'b0, m_shadow});
    chk("cfg_q_2", bus2.cfg_q, {m_pending, 1'b0, m_shadow});
    chk("excl_1", 8'(up1 & boost1), 8'h00);
  endtask

  // One clk28 cycle: drive at negedge, model at posedge, check at next negedge.
  task automatic step(input logic hs, input logic vs, input logic wr, input logic [7:0] d);
    hsync_start = hs;
    vsync_start = vs;
    cfg_wr      = wr;
    cfg_data    = d;
    ck7         = (cyc % 4) == 0;
    cyc++;
    @(posedge clk28);
    model_edge();
    @(negedge clk28);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic run_frames(input int frames, input int lines, input int len);
    for (int f = 0; f < frames; f++)
      for (int l = 0; l < lines; l++)
        for (int c = 0; c < len; c++)
          step(c == 0, (c == 0) && (l == 0), 1'b0, 8'h00);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_strobe"}, {6'd0, strobe2, strobe1}, 8'h03);
    chk({tag, "_up"},     {6'd0, up2, up1},         8'h00);
    chk({tag, "_boost"},  {6'd0, boost2, boost1},   8'h00);
    chk({tag, "_cfg_q1"}, bus1.cfg_q, 8'h00);
    chk({tag, "_cfg_q2"}, bus2.cfg_q, 8'h00);
    model_reset();
    @(negedge clk28);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset state, then ULA+ on with zero config
    async_reset("rst0");
    ulaplus_active = 1'b1;
    idle(3);
    chk("t1_up", 8'(up1), 8'h00);
    chk("t1_strobe", 8'(strobe1), 8'h01);

    // 2: boost write waits for frame start
    step(1'b0, 1'b0, 1'b1, 8'h02);
    chk("t2_pending_q", bus1.cfg_q, 8'h82);
    idle(5);
    chk("t2_boost_held", 8'(boost1), 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t2_boost_vs_edge", 8'(boost1), 8'h00);
    idle(1);
    chk("t2_boost_on", 8'(boost1), 8'h01);
    chk("t2_applied_q", bus1.cfg_q, 8'h02);

    // 3: pixel dither with ULA+ allowed, applied at frame start
    step(1'b0, 1'b0, 1'b1, 8'h05);
    idle(3);
    run_frames(1, 3, 24);
    chk("t3_up", 8'(up1), 8'h01);
    chk("t3_boost", 8'(boost1), 8'h00);

    // 4: immediate apply, pixel^line dither
    step(1'b0, 1'b0, 1'b1, 8'h2C);
    chk("t4_q", bus1.cfg_q, 8'h2C);
    for (int l = 0; l < 4; l++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00);
      idle(17);
    end

    // 5: priority between up_en and bright_boost
    ulaplus_active = 1'b1;
    step(1'b0, 1'b0, 1'b1, 8'h23);
    idle(2);
    chk("t5_up", 8'(up1), 8'h01);
    chk("t5_boost", 8'(boost1), 8'h00);
    ulaplus_active = 1'b0;
    idle(1);
    chk("t5_up_off", 8'(up1), 8'h00);
    chk("t5_boost_on", 8'(boost1), 8'h01);

    // 6: write on the frame-start edge, then frame-phase divide, then async reset mid-line
    step(1'b1, 1'b1, 1'b1, 8'h14);
    chk("t6_q", bus2.cfg_q, 8'h14);
    idle(10);
    run_frames(5, 3, 20);
    idle(7);
    async_reset("rst_mid");

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      logic hs, vs, wr;
      logic [7:0] d;
      hs = $urandom_range(0, 29) == 0;
      vs = $urandom_range(0, 149) == 0;
      wr = $urandom_range(0, 39) == 0;
      d  = 8'($urandom);
      if ($urandom_range(0, 49) == 0) ulaplus_active = ~ulaplus_active;
      step(hs, vs, wr, d);
      if (i == 1300) async_reset("rst_rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
